reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Register-hazard scoreboard that sequences instruction issue against the 32-entry, 64-bit integer register file. It tracks which architectural registers have a write in flight, holds issue when a source or destination conflicts with a pending write, and releases registers when writeback reaches the register file write port. It sits between decode/issue and the register file read stage, and also provides a stall counter and a protocol-error flag for debug.

## Interface
- No parameters: register count fixed at 32, address width 5.
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-high.
- issue_valid  in  1  decode presents an instruction.
- issue_ready  out  1  scoreboard accepts it; combinational from current state and inputs.
- issue_rs1_en / issue_rs2_en  in  1 each  source operand read enables.
- issue_rs1 / issue_rs2  in  5 each  source register addresses.
- issue_rd_en  in  1  instruction writes a destination.
- issue_rd  in  5  destination address.
- wb_valid  in  1  writeback this cycle; same qualifier as the register file WriteEnable.
- wb_addr  in  5  writeback address; same as the register file WriteAddr.
- flush  in  1  pipeline flush; abandons all in-flight writes.
- busy_vec  out  32  registered per-register pending-write bits; bit 0 always 0.
- outstanding  out  6  registered population count of busy_vec, 0..31.
- stall_cycles  out  32  saturating count of cycles with issue_valid=1 and issue_ready=0.
- err  out  1  sticky protocol error.

## Operation
- An operand conflicts when its enable is 1, its address is nonzero, busy_vec[addr]=1, and it is not being released this cycle. A release is wb_valid=1 with wb_addr equal to the operand address.
  - Release bypass is legal because the register file forwards WriteData on a read/write address match.
- issue_ready=1 when rst=0, flush=0, and none of rs1, rs2 or rd conflicts. A destination conflict is WAW and stalls; one write in flight per register.
- Issue fire = issue_valid & issue_ready. On fire with issue_rd_en=1 and issue_rd≠0, busy_vec[issue_rd] sets at the next edge.
- Writeback with wb_valid=1 and wb_addr≠0 clears busy_vec[wb_addr] at the next edge.
- Same register set and cleared in one cycle: set wins, so busy stays 1.
- Writeback with wb_valid=1, wb_addr≠0 and busy_vec[wb_addr]=0: err sets and stays set until rst. The clear is a no-op.
- wb_addr=0 is ignored and never errors. x0 is never marked busy.
- flush=1: at the next edge every busy bit clears and outstanding=0.
  - A wb_valid in the same cycle raises no err.
  - No issue fires, because issue_ready=0.
  - stall_cycles does not count that cycle.
- outstanding is recomputed from the next-state busy vector, so it always equals popcount(busy_vec) in the same cycle.
- stall_cycles holds at 0xFFFF_FFFF once it saturates.

## Timing
- Reset values: busy_vec=0, outstanding=0, stall_cycles=0, err=0. issue_ready=0 while rst=1.
- rst asserted mid-operation: all state clears at that edge. Pending writebacks arriving after reset are flagged as err.
- Issue path latency is 0 cycles: issue_ready responds in the same cycle as the inputs.
- State update latency is 1 cycle: busy_vec reflects a fire or writeback on the edge after it.
- Back-to-back dependent issue:
  - The producer fires in cycle N.
  - The consumer stalls from N+1 until the writeback cycle W.
  - The consumer may fire in W, using the bypass.
- issue_valid may drop while stalled; the scoreboard keeps no issue-side state.

## Test plan
- Reset, then issue rd=5 with no sources -> ready=1; busy_vec=0x0000_0020 and outstanding=1 one cycle later.
- RAW hazard: x5 pending, issue rs1=5 for 3 cycles, then wb_valid with wb_addr=5 -> ready=0 for 3 cycles, ready=1 in the writeback cycle, stall_cycles=3.
- WAW plus simultaneous set/clear: x7 pending, then in one cycle wb_addr=7 and issue rd=7 -> ready=1 and busy_vec[7] stays 1.
- x0 handling: issue rd=0 and rs1=0 repeatedly, plus wb_addr=0 -> busy_vec stays 0, ready=1, err=0.
- Spurious writeback: wb_valid with wb_addr=9 while x9 not busy -> err=1 next cycle and held through later traffic until rst.
- Flush and reset mid-operation: x1, x2, x3 pending, then flush -> busy_vec=0 and outstanding=0 next cycle. Then x4 pending, then rst -> all outputs return to reset values.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard for the 32 x 64-bit integer register file.
// Tracks in-flight writes, holds conflicting issue, releases on writeback.
module reg_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic        issue_rs1_en,
  input  logic        issue_rs2_en,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic        issue_rd_en,
  input  logic [4:0]  issue_rd,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic        flush,
  output logic [31:0] busy_vec,
  output logic [5:0]  outstanding,
  output logic [31:0] stall_cycles,
  output logic        err
);

  logic        wb_hit;
  logic        rs1_conf;
  logic        rs2_conf;
  logic        rd_conf;
  logic        fire;
  logic        stall;
  logic        spurious;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic [31:0] busy_nxt;
  logic [5:0]  pop_nxt;

  assign wb_hit = wb_valid && (wb_addr != 5'd0);

  // A release in the same cycle is not a conflict: the regfile forwards.
  assign rs1_conf = issue_rs1_en && (issue_rs1 != 5'd0) &&
                    busy_vec[issue_rs1] &&
                    !(wb_valid && (wb_addr == issue_rs1));
  assign rs2_conf = issue_rs2_en && (issue_rs2 != 5'd0) &&
                    busy_vec[issue_rs2] &&
                    !(wb_valid && (wb_addr == issue_rs2));
  assign rd_conf  = issue_rd_en && (issue_rd != 5'd0) &&
                    busy_vec[issue_rd] &&
                    !(wb_valid && (wb_addr == issue_rd));

  assign issue_ready = !rst && !flush &&
                       !rs1_conf && !rs2_conf && !rd_conf;
  assign fire     = issue_valid && issue_ready;
  assign stall    = issue_valid && !issue_ready && !flush;
  assign spurious = wb_hit && !busy_vec[wb_addr] && !flush;

  always_comb begin
    set_vec = 32'd0;
    clr_vec = 32'd0;
    if (fire && issue_rd_en && (issue_rd != 5'd0))
      set_vec[issue_rd] = 1'b1;
    if (wb_hit)
      clr_vec[wb_addr] = 1'b1;
  end

  // Set wins over clear so a re-issue to a releasing register stays busy.
  always_comb begin
    if (flush) busy_nxt = 32'd0;
    else       busy_nxt = (busy_vec & ~clr_vec) | set_vec;
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    pop_nxt = 6'd0;
    for (int i = 1; i < 32; i++)
      pop_nxt = pop_nxt + {5'd0, busy_nxt[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec     <= 32'd0;
      outstanding  <= 6'd0;
      stall_cycles <= 32'd0;
      err          <= 1'b0;
    end else begin
      busy_vec    <= busy_nxt;
      outstanding <= pop_nxt;
      if (stall && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (spurious)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
// One task per scenario, hand-computed expectations.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic        issue_rs1_en;
  logic        issue_rs2_en;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_rd_en;
  logic [4:0]  issue_rd;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic        flush;
  logic [31:0] busy_vec;
  logic [5:0]  outstanding;
  logic [31:0] stall_cycles;
  logic        err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk),
    .rst(rst),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_rs1_en(issue_rs1_en),
    .issue_rs2_en(issue_rs2_en),
    .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2),
    .issue_rd_en(issue_rd_en),
    .issue_rd(issue_rd),
    .wb_valid(wb_valid),
    .wb_addr(wb_addr),
    .flush(flush),
    .busy_vec(busy_vec),
    .outstanding(outstanding),
    .stall_cycles(stall_cycles),
    .err(err)
  );

  task automatic idle();
    issue_valid  = 1'b0;
    issue_rs1_en = 1'b0;
    issue_rs2_en = 1'b0;
    issue_rs1    = 5'd0;
    issue_rs2    = 5'd0;
    issue_rd_en  = 1'b0;
    issue_rd     = 5'd0;
    wb_valid     = 1'b0;
    wb_addr      = 5'd0;
    flush        = 1'b0;
  endtask

  // Advance one edge; outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_rd_only(input logic [4:0] rd);
    idle();
    issue_valid = 1'b1;
    issue_rd_en = 1'b1;
    issue_rd    = rd;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    issue_valid = 1'b1;
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready got=%b want=0", issue_ready);
    end
    step();
    step();
    rst = 1'b0;
    idle();
    #1;
    checks++;
    if (busy_vec !== 32'd0 || outstanding !== 6'd0 ||
        stall_cycles !== 32'd0 || err !== 1'b0) begin
      failures++;
      $display("FAIL rst_state got=%h/%0d/%0d/%b want=0/0/0/0",
               busy_vec, outstanding, stall_cycles, err);
    end
  endtask

  task automatic test_issue();
    issue_rd_only(5'd5);
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready got=%b want=1", issue_ready);
    end
    step();
    idle();
    checks++;
    if (busy_vec !== 32'h0000_0020 || outstanding !== 6'd1) begin
      failures++;
      $display("FAIL issue_busy got=%h/%0d want=00000020/1",
               busy_vec, outstanding);
    end
  endtask

  task automatic test_raw();
    idle();
    issue_valid  = 1'b1;
    issue_rs1_en = 1'b1;
    issue_rs1    = 5'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (issue_ready !== 1'b0) begin
        failures++;
        $display("FAIL raw_stall%0d got=%b want=0", i, issue_ready);
      end
      step();
    end
    wb_valid = 1'b1;
    wb_addr  = 5'd5;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL raw_bypass got=%b want=1", issue_ready);
    end
    step();
    idle();
    checks++;
    if (stall_cycles !== 32'd3 || busy_vec !== 32'd0 || err !== 1'b0) begin
      failures++;
      $display("FAIL raw_after got=%0d/%h/%b want=3/0/0",
               stall_cycles, busy_vec, err);
    end
  endtask

  task automatic test_waw();
    issue_rd_only(5'd7);
    step();
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL waw_stall got=%b want=0", issue_ready);
    end
    step();
    checks++;
    if (stall_cycles !== 32'd4) begin
      failures++;
      $display("FAIL waw_stall_cnt got=%0d want=4", stall_cycles);
    end
    wb_valid = 1'b1;
    wb_addr  = 5'd7;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL waw_setclr_ready got=%b want=1", issue_ready);
    end
    step();
    idle();
    checks++;
    if (busy_vec !== 32'h0000_0080 || outstanding !== 6'd1 || err !== 1'b0) begin
      failures++;
      $display("FAIL waw_setclr got=%h/%0d/%b want=00000080/1/0",
               busy_vec, outstanding, err);
    end
    wb_valid = 1'b1;
    wb_addr  = 5'd7;
    step();
    idle();
    checks++;
    if (busy_vec !== 32'd0 || outstanding !== 6'd0) begin
      failures++;
      $display("FAIL waw_release got=%h/%0d want=0/0", busy_vec, outstanding);
    end
  endtask

  task automatic test_x0();
    issue_rd_only(5'd0);
    issue_rs1_en = 1'b1;
    issue_rs1    = 5'd0;
    wb_valid     = 1'b1;
    wb_addr      = 5'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (issue_ready !== 1'b1) begin
        failures++;
        $display("FAIL x0_ready%0d got=%b want=1", i, issue_ready);
      end
      step();
    end
    idle();
    checks++;
    if (busy_vec !== 32'd0 || outstanding !== 6'd0 || err !== 1'b0) begin
      failures++;
      $display("FAIL x0_state got=%h/%0d/%b want=0/0/0",
               busy_vec, outstanding, err);
    end
  endtask

  task automatic test_spurious();
    idle();
    wb_valid = 1'b1;
    wb_addr  = 5'd9;
    step();
    idle();
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL spur_err got=%b want=1", err);
    end
    issue_rd_only(5'd3);
    step();
    idle();
    wb_valid = 1'b1;
    wb_addr  = 5'd3;
    step();
    idle();
    checks++;
    if (err !== 1'b1 || busy_vec !== 32'd0) begin
      failures++;
      $display("FAIL spur_sticky got=%b/%h want=1/0", err, busy_vec);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL spur_rst got=%b want=0", err);
    end
  endtask

  task automatic test_flush_reset();
    for (int r = 1; r <= 3; r++) begin
      issue_rd_only(r[4:0]);
      step();
    end
    idle();
    checks++;
    if (busy_vec !== 32'h0000_000E || outstanding !== 6'd3) begin
      failures++;
      $display("FAIL fl_pending got=%h/%0d want=0000000e/3",
               busy_vec, outstanding);
    end
    issue_rd_only(5'd4);
    flush    = 1'b1;
    wb_valid = 1'b1;
    wb_addr  = 5'd9;
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      failures++;
      $display("FAIL fl_ready got=%b want=0", issue_ready);
    end
    step();
    idle();
    checks++;
    if (busy_vec !== 32'd0 || outstanding !== 6'd0 ||
        err !== 1'b0 || stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL fl_state got=%h/%0d/%b/%0d want=0/0/0/0",
               busy_vec, outstanding, err, stall_cycles);
    end
    issue_rd_only(5'd4);
    step();
    idle();
    checks++;
    if (busy_vec !== 32'h0000_0010 || outstanding !== 6'd1) begin
      failures++;
      $display("FAIL fl_x4 got=%h/%0d want=00000010/1", busy_vec, outstanding);
    end
    issue_valid  = 1'b1;
    issue_rs1_en = 1'b1;
    issue_rs1    = 5'd4;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    checks++;
    if (busy_vec !== 32'd0 || outstanding !== 6'd0 ||
        stall_cycles !== 32'd0 || err !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst got=%h/%0d/%0d/%b want=0/0/0/0",
               busy_vec, outstanding, stall_cycles, err);
    end
    wb_valid = 1'b1;
    wb_addr  = 5'd4;
    step();
    idle();
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL late_wb_err got=%b want=1", err);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    test_reset();
    test_issue();
    test_raw();
    test_waw();
    test_x0();
    test_spurious();
    test_flush_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
